// File: rtl/user_key_ctrl.sv
// Eight-key debouncer with press-edge latches, interrupt mask and a 4-word read/write register port.
// Optional interrupt block under `USER_KEY_IRQ_EN`; without it IRQ is 0 and only addr 0 reads non-zero.
module user_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  key_in,
    input  logic [1:0]  addr,
    input  logic        WE,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        IRQ
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]         sync1;
    logic [7:0]         sync2;
    logic [7:0]         deb;
    logic [7:0][CW-1:0] cnt;
    logic [7:0]         edge_bits;
    logic [7:0]         mask_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    // Difference held for the full window: accept the new level.
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef USER_KEY_IRQ_EN
    logic [7:0] rise;
    logic [7:0] clr;
    logic       unused_wdata;

    assign unused_wdata = ^Wdata[31:8];

    always_comb begin
        rise = '0;
        for (int i = 0; i < 8; i++) begin
            rise[i] = ~deb[i] & sync2[i] & (cnt[i] == CNT_MAX);
        end
        clr = (WE && addr == 2'd1) ? Wdata[7:0] : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_bits <= '0;
            mask_bits <= '0;
        end else begin
            // Set is ORed in after the clear so a same-cycle press survives W1C.
            edge_bits <= (edge_bits & ~clr) | rise;
            if (WE && addr == 2'd2) begin
                mask_bits <= Wdata[7:0];
            end
        end
    end

    assign IRQ = |(edge_bits & mask_bits);
`else
    logic unused_bus;

    assign unused_bus = ^{WE, Wdata};
    assign edge_bits  = '0;
    assign mask_bits  = '0;
    assign IRQ        = 1'b0;
`endif

    always_comb begin
        Rdata = 32'h0;
        case (addr)
            2'd0:    Rdata = {24'h0, deb};
            2'd1:    Rdata = {24'h0, edge_bits};
            2'd2:    Rdata = {24'h0, mask_bits};
            default: Rdata = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_user_key_ctrl.sv
// Directed bench for user_key_ctrl with DEBOUNCE_CYCLES=4; expectations follow the USER_KEY_IRQ_EN build setting.
module tb_user_key_ctrl;
    localparam int D = 4;
`ifdef USER_KEY_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  key_in;
    logic [1:0]  addr;
    logic        WE;
    logic [31:0] Wdata;
    logic [31:0] Rdata;
    logic        IRQ;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  key;
        logic [1:0]  a;
        logic        we;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    user_key_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .addr(addr),
        .WE(WE), .Wdata(Wdata), .Rdata(Rdata), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Value a full build would read; addr 1/2 read 0 when the interrupt block is absent.
    function automatic logic [31:0] en_val(input logic [1:0] a, input logic [31:0] v);
        return (a == 2'd0 || IRQ_EN) ? v : 32'h0;
    endfunction

    task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] v);
        addr = a;
        #1;
        check(name, Rdata, en_val(a, v));
    endtask

    task automatic add(input logic [7:0] k, input logic [1:0] a, input logic we,
                       input logic [31:0] wd, input logic [31:0] e, input logic ei);
        vec_t v;
        v.key = k; v.a = a; v.we = we; v.wd = wd; v.exp_rd = e; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; key_in = 8'h00; addr = 2'd0; WE = 1'b0; Wdata = 32'h0;
        #1;
        for (int a = 0; a < 4; a++) read_chk("reset_read", 2'(a), 32'h0);
        check("reset_irq", {31'h0, IRQ}, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Single press, mask load, W1C, dual press, partial clear, ignored writes.
        for (int i = 0; i < 5; i++) add(8'h01, 2'd0, 1'b0, 32'h0, 32'h00, 1'b0);
        add(8'h01, 2'd0, 1'b0, 32'h0,        32'h01, 1'b0);
        add(8'h01, 2'd1, 1'b0, 32'h0,        32'h01, 1'b0);
        add(8'h01, 2'd2, 1'b1, 32'h4,        32'h04, 1'b0);
        add(8'h01, 2'd1, 1'b1, 32'h1,        32'h00, 1'b0);
        for (int i = 0; i < 5; i++) add(8'h25, 2'd1, 1'b0, 32'h0, 32'h00, 1'b0);
        add(8'h25, 2'd1, 1'b0, 32'h0,        32'h24, 1'b1);
        add(8'h25, 2'd1, 1'b1, 32'h4,        32'h20, 1'b0);
        add(8'h25, 2'd0, 1'b1, 32'hFF,       32'h25, 1'b0);
        add(8'h25, 2'd3, 1'b1, 32'hFFFFFFFF, 32'h00, 1'b0);
        add(8'h25, 2'd2, 1'b0, 32'h0,        32'h04, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            key_in = vecs[i].key; addr = vecs[i].a; WE = vecs[i].we; Wdata = vecs[i].wd;
            tick();
            check($sformatf("vec%0d_rdata", i), Rdata, en_val(vecs[i].a, vecs[i].exp_rd));
            check($sformatf("vec%0d_irq", i), {31'h0, IRQ}, {31'h0, vecs[i].exp_irq & IRQ_EN});
        end
        WE = 1'b0;

        // Three-cycle glitch on key 3 must be discarded.
        for (int c = 0; c < 10; c++) begin
            key_in = (c < 3) ? 8'h2D : 8'h25;
            tick();
            read_chk("glitch_deb", 2'd0, 32'h25);
            read_chk("glitch_edge", 2'd1, 32'h20);
            check("glitch_irq", {31'h0, IRQ}, 32'h0);
        end

        // Release key 0 (no edge), clear all, then W1C bit 0 on the cycle it re-rises.
        key_in = 8'h24;
        repeat (D + 2) tick();
        read_chk("release_deb", 2'd0, 32'h24);
        read_chk("release_edge", 2'd1, 32'h20);
        addr = 2'd1; WE = 1'b1; Wdata = 32'hFF;
        tick();
        WE = 1'b0;
        key_in = 8'h25;
        repeat (D + 1) tick();
        read_chk("race_pre_deb", 2'd0, 32'h24);
        addr = 2'd1; WE = 1'b1; Wdata = 32'h1;
        tick();
        WE = 1'b0;
        read_chk("race_edge", 2'd1, 32'h01);
        read_chk("race_deb", 2'd0, 32'h25);

        // Reset mid-count with key 1 pressed.
        key_in = 8'h27;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        for (int a = 0; a < 4; a++) read_chk("midreset_read", 2'(a), 32'h0);
        check("midreset_irq", {31'h0, IRQ}, 32'h0);
        tick();
        reset = 1'b0;
        repeat (D + 1) tick();
        read_chk("post_reset_deb5", 2'd0, 32'h00);
        tick();
        read_chk("post_reset_deb6", 2'd0, 32'h27);
        read_chk("post_reset_edge", 2'd1, 32'h27);
        check("post_reset_irq", {31'h0, IRQ}, 32'h0);

        // Key 7 press then full mask.
        key_in = 8'hA7;
        repeat (D + 2) tick();
        read_chk("key7_deb", 2'd0, 32'hA7);
        addr = 2'd2; WE = 1'b1; Wdata = 32'hFF;
        tick();
        WE = 1'b0;
        read_chk("key7_mask", 2'd2, 32'hFF);
        read_chk("key7_edge", 2'd1, 32'hA7);
        check("key7_irq", {31'h0, IRQ}, {31'h0, IRQ_EN});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/user_key_ctrl.md
USER_KEY_CTRL -- requirements
Module: user_key_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, the number of consecutive stable clk cycles needed to accept a key change (minimum 2).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port key_in, input, 8, raw user keys, active-high (1 = pressed), asynchronous to clk.
REQ-005 SHALL have port addr, input, 2, register select (bridge address bits [3:2]).
REQ-006 SHALL have port WE, input, 1, bus write strobe for the current cycle.
REQ-007 SHALL have port Wdata, input, 32, bus write data.
REQ-008 SHALL have port Rdata, output, 32, combinational bus read data.
REQ-009 SHALL have port IRQ, output, 1, level interrupt request to the bridge (HWint line).

Function
REQ-010 SHALL pass each key_in bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep, per key, a debounced bit deb[i] and an independent counter sized to hold DEBOUNCE_CYCLES-1.
REQ-012 SHALL clear cnt[i] on any cycle where the synchronized bit equals deb[i].
REQ-013 SHALL increment cnt[i] while the synchronized bit differs from deb[i]; at cnt[i]==DEBOUNCE_CYCLES-1 with the difference still present, deb[i] SHALL toggle and cnt[i] SHALL clear.
REQ-014 SHALL give a clean edge a latency of 2 (sync) + DEBOUNCE_CYCLES cycles from key_in change to deb change.
REQ-015 SHALL discard a glitch shorter than DEBOUNCE_CYCLES synchronized cycles; deb SHALL stay unchanged and the counter SHALL restart from 0.
REQ-016 SHALL set EDGE[i] on the cycle deb[i] goes 0->1 (press); release (1->0) SHALL NOT set EDGE.
REQ-017 SHALL read as follows: addr 0 = {24'b0, deb}; 1 = {24'b0, EDGE}; 2 = {24'b0, MASK}; 3 = 32'b0.
REQ-018 SHALL, on WE with addr 1, clear each EDGE bit whose Wdata bit is 1 (write-1-to-clear, Wdata[31:8] ignored).
REQ-019 SHALL, on WE with addr 2, load MASK <= Wdata[7:0]; writes to addr 0 and 3 SHALL be ignored.
REQ-020 SHALL let set win when a W1C clear and a new press hit the same EDGE bit in the same cycle.
REQ-021 SHALL drive IRQ = |(EDGE & MASK) combinationally from registers (asserts the cycle after the setting edge, deasserts the cycle after the clear or mask write).
REQ-022 SHALL debounce all 8 keys independently; simultaneous presses SHALL set multiple EDGE bits in the same cycle.

Reset
REQ-023 SHALL, while reset is high, asynchronously force synchronizer flops, deb, cnt, EDGE and MASK to 0; Rdata then reads 0 for every addr and IRQ is 0.
REQ-024 SHALL abandon a debounce in progress at reset; after release, a key already held SHALL register as a fresh press after 2+DEBOUNCE_CYCLES cycles.

Configuration
REQ-025 SHALL use macro USER_KEY_IRQ_EN: when defined, EDGE, MASK and IRQ behave as above.
REQ-026 SHALL, with USER_KEY_IRQ_EN undefined, tie IRQ to 0, omit EDGE/MASK storage, read addr 1 and 2 as 0, and ignore all writes; debounce and addr 0 are unchanged.

Verification (DEBOUNCE_CYCLES=4, USER_KEY_IRQ_EN defined unless stated)
REQ-027 SHALL cover: key_in=8'h01 held steady -> addr0 reads 8'h01 exactly 6 cycles later; addr1 reads 8'h01.
REQ-028 SHALL cover: key_in[3] pulsed high for 3 cycles -> deb, EDGE stay 0; IRQ never asserts.
REQ-029 SHALL cover: MASK=8'h04, press keys 2 and 5 together -> EDGE=8'h24, IRQ=1; write 32'h4 to addr1 -> EDGE=8'h20, IRQ=0 next cycle.
REQ-030 SHALL cover: W1C of bit 0 on the same cycle deb[0] rises -> EDGE[0]=1 afterwards.
REQ-031 SHALL cover: reset asserted mid-count with key held -> all reads 0, IRQ=0; after release, deb=1 after 6 cycles.
REQ-032 SHALL cover: build without USER_KEY_IRQ_EN, press key 7, write 32'hFF to addr2 -> addr0=8'h80, addr1=addr2=0, IRQ=0.
